// File: rtl/arith_pkg.sv
// Shared definitions for the serial arithmetic blocks: FSM state encoding and default operand width.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } serial_state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/fa_1bit.sv
// Single-bit full adder cell used by the serial arithmetic datapaths.
module fa_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/sub_nbit_serial_using_fa_1bit.sv
// Bit-serial subtractor diff = a - b - bin, LSB first, one bit per clock through one fa_1bit cell.
// Define SUB_SERIAL_OVF_EN to add the signed-overflow output ovf.
module sub_nbit_serial_using_fa_1bit
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    serial_state_t    state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] diff_reg, diff_next;
    logic             bout_reg, bout_next;
    logic             carry_reg, carry_next;
    logic [CW-1:0]    count_reg, count_next;
`ifdef SUB_SERIAL_OVF_EN
    logic             ovf_reg, ovf_next;
`endif

    logic fa_a, fa_b, fa_sum, fa_cout;

    // Subtraction as a + ~b + carry, with the carry seeded by ~bin at acceptance.
    assign fa_a = a_reg[count_reg];
    assign fa_b = ~b_reg[count_reg];

    fa_1bit u_fa (
        .a    (fa_a),
        .b    (fa_b),
        .cin  (carry_reg),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Only the bit under the counter is written; the rest hold their previous value.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_diff_bit
            assign diff_next[gi] = (state_reg == RUN && count_reg == CW'(gi)) ? fa_sum
                                                                               : diff_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        bout_next  = bout_reg;
        carry_next = carry_reg;
        count_next = count_reg;
`ifdef SUB_SERIAL_OVF_EN
        ovf_next   = ovf_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    a_next     = a;
                    b_next     = b;
                    carry_next = ~bin;
                    count_next = '0;
                end
            end
            RUN: begin
                carry_next = fa_cout;
                if (count_reg == LAST_BIT) begin
                    state_next = DONE;
                    count_next = '0;
                    bout_next  = ~fa_cout;
`ifdef SUB_SERIAL_OVF_EN
                    ovf_next   = carry_reg ^ fa_cout;
`endif
                end else begin
                    count_next = count_reg + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            diff_reg  <= '0;
            bout_reg  <= 1'b0;
            carry_reg <= 1'b0;
            count_reg <= '0;
`ifdef SUB_SERIAL_OVF_EN
            ovf_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            diff_reg  <= diff_next;
            bout_reg  <= bout_next;
            carry_reg <= carry_next;
            count_reg <= count_next;
`ifdef SUB_SERIAL_OVF_EN
            ovf_reg   <= ovf_next;
`endif
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = (state_reg == DONE);
    assign diff = diff_reg;
    assign bout = bout_reg;
`ifdef SUB_SERIAL_OVF_EN
    assign ovf  = ovf_reg;
`endif

endmodule

// File: tb/tb_sub_nbit_serial_using_fa_1bit.sv
// Self-checking bench for sub_nbit_serial_using_fa_1bit: directed vector table, handshake corner cases, random ops.
module tb_sub_nbit_serial_using_fa_1bit;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         busy, done, bout;
    logic [W-1:0] diff;
`ifdef SUB_SERIAL_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;
    int done_count = 0;

    logic [W-1:0] obs_diff;
    logic         obs_bout;
    logic         obs_ovf;

    sub_nbit_serial_using_fa_1bit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SUB_SERIAL_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_count++;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] exp_diff;
        logic         exp_bout;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic logic [W:0] model_sub(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                             input logic mbin);
        int r;
        logic [W-1:0] d;
        r = int'(ma) - int'(mb) - int'(mbin);
        d = W'(r & ((1 << W) - 1));
        return {(r < 0), d};
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic mbin);
        int sa, sb, r;
        sa = ma[W-1] ? int'(ma) - (1 << W) : int'(ma);
        sb = mb[W-1] ? int'(mb) - (1 << W) : int'(mb);
        r  = sa - sb - int'(mbin);
        return (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
    endfunction

    // One full handshake; checks latency and the post-done return to idle.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin);
        int lat;
        @(negedge clk);
        a = ta; b = tb_; bin = tbin; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); bin = 1'(($urandom));
        chk("busy_after_start", busy, 1);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (done !== 1'b1 && lat < W + 4);
        chk("latency", lat, W);
        obs_diff = diff;
        obs_bout = bout;
`ifdef SUB_SERIAL_OVF_EN
        obs_ovf = ovf;
`else
        obs_ovf = 1'b0;
`endif
        @(posedge clk);
        #1;
        chk("busy_after_done", busy, 0);
        chk("done_pulse_len", done, 0);
    endtask

    initial begin
        logic [W:0] m;
        int dc0;

        vecs[0] = '{4'd9,  4'd5,  1'b0, 4'd4,  1'b0};
        vecs[1] = '{4'd3,  4'd5,  1'b0, 4'hE,  1'b1};
        vecs[2] = '{4'd0,  4'd0,  1'b1, 4'hF,  1'b1};
        vecs[3] = '{4'd15, 4'd1,  1'b0, 4'd14, 1'b0};
        vecs[4] = '{4'd6,  4'd6,  1'b0, 4'd0,  1'b0};
        vecs[5] = '{4'd15, 4'd15, 1'b1, 4'hF,  1'b1};
        vecs[6] = '{4'd0,  4'd15, 1'b0, 4'd1,  1'b1};
        vecs[7] = '{4'd15, 4'd0,  1'b1, 4'd14, 1'b0};

        #12;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_diff", diff, 0);
        chk("reset_bout", bout, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin);
            chk($sformatf("vec%0d_diff", i), obs_diff, vecs[i].exp_diff);
            chk($sformatf("vec%0d_bout", i), obs_bout, vecs[i].exp_bout);
            $display("vec %0d: a=%0d b=%0d bin=%0d -> diff=%0h bout=%0d", i, vecs[i].a,
                     vecs[i].b, vecs[i].bin, obs_diff, obs_bout);
        end

        // Busy lockout: a second start two cycles in must be ignored.
        dc0 = done_count;
        @(negedge clk);
        a = 4'd15; b = 4'd1; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a = 4'd0; b = 4'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (W + 8) @(negedge clk);
        chk("lockout_done_count", done_count - dc0, 1);
        chk("lockout_diff", diff, 14);
        chk("lockout_bout", bout, 0);
        chk("lockout_idle", busy, 0);
        $display("lockout: dones=%0d diff=%0d bout=%0d", done_count - dc0, diff, bout);

        // Reset mid-operation, asserted away from any clock edge.
        dc0 = done_count;
        @(negedge clk);
        a = 4'd12; b = 4'd4; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_diff", diff, 0);
        chk("midrst_bout", bout, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4'd6, 4'd6, 1'b0);
        chk("midrst_diff2", obs_diff, 0);
        chk("midrst_bout2", obs_bout, 0);
        chk("midrst_done_count", done_count - dc0, 1);
        $display("mid-reset: dones=%0d diff=%0d bout=%0d", done_count - dc0, obs_diff, obs_bout);

`ifdef SUB_SERIAL_OVF_EN
        run_op(4'd7, 4'd15, 1'b0);
        chk("ovf1_diff", obs_diff, 4'h8);
        chk("ovf1_bout", obs_bout, 1);
        chk("ovf1_ovf", obs_ovf, 1);
        run_op(4'd2, 4'd1, 1'b0);
        chk("ovf0_ovf", obs_ovf, 0);
        $display("ovf: last ovf=%0d", obs_ovf);
`endif

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            logic rbin;
            ra = W'($urandom);
            rb = W'($urandom);
            rbin = 1'($urandom);
            m = model_sub(ra, rb, rbin);
            run_op(ra, rb, rbin);
            chk("rand_diff", obs_diff, m[W-1:0]);
            chk("rand_bout", obs_bout, m[W]);
`ifdef SUB_SERIAL_OVF_EN
            chk("rand_ovf", obs_ovf, model_ovf(ra, rb, rbin));
`endif
            $display("rand %0d: a=%0d b=%0d bin=%0d -> diff=%0h bout=%0d ovf=%0d", i, ra, rb,
                     rbin, obs_diff, obs_bout, obs_ovf);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
